pipe_stage_buffer: RTL and testbench

- Generalised inter-stage pipeline register for the MIPS pipeline. It carries an arbitrary-width payload plus valid and halted bits across DEPTH register slices.
- Adds two things the per-field IF/ID buffer lacks: flush (bubble insertion) and stall/flush event counters.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB with per-site parameters. It replaces the hand-built per-field lock registers.

---
 rtl/pipe_stage_buffer.sv | 65 ++++++
 tb/tb_pipe_stage_buffer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buffer.sv
// rtl/pipe_stage_buffer.sv - multi-slice inter-stage pipeline register with flush, stall and event counters
module pipe_stage_buffer #(
    parameter int                DATA_W      = 64,
    parameter int                DEPTH       = 1,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = '0,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_halted,
    input  logic              lock,
    input  logic              flush,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("pipe_stage_buffer: DEPTH must be in 1..4");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  halted_q;

    // Flush overrides lock so a mispredict squash is never held off by a stall.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
            valid_q   <= '0;
            halted_q  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) data_q[k] <= BUBBLE_DATA;
            valid_q  <= '0;
            halted_q <= '0;
            if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
        end else if (lock) begin
            if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
        end else begin
            data_q[0]   <= in_data;
            valid_q[0]  <= in_valid;
            halted_q[0] <= in_halted;
            for (int k = 1; k < DEPTH; k++) begin
                data_q[k]   <= data_q[k-1];
                valid_q[k]  <= valid_q[k-1];
                halted_q[k] <= halted_q[k-1];
            end
        end
    end

    assign out_data   = data_q[DEPTH-1];
    assign out_valid  = valid_q[DEPTH-1];
    assign out_halted = halted_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb/tb_pipe_stage_buffer.sv - self-checking bench for pipe_stage_buffer
module tb_pipe_stage_buffer;

    localparam logic [63:0] BUB_C = 64'hDEAD_BEEF_0000_0001;

    logic        clk = 1'b0;
    logic        rst_b, in_valid, in_halted, lock, flush;
    logic [63:0] in_data;

    logic [63:0] a_data, b_data, c_data;
    logic        a_valid, b_valid, c_valid, a_halted, b_halted, c_halted;
    logic [15:0] a_stall, a_flush, b_stall, b_flush;
    logic [3:0]  c_stall, c_flush;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_buffer #(.DATA_W(64), .DEPTH(1), .BUBBLE_DATA(64'h0), .CNT_W(16)) u_a (
        .clk(clk), .rst_b(rst_b), .in_data(in_data), .in_valid(in_valid), .in_halted(in_halted),
        .lock(lock), .flush(flush), .out_data(a_data), .out_valid(a_valid), .out_halted(a_halted),
        .stall_cnt(a_stall), .flush_cnt(a_flush));

    pipe_stage_buffer #(.DATA_W(64), .DEPTH(3), .BUBBLE_DATA(64'h0), .CNT_W(16)) u_b (
        .clk(clk), .rst_b(rst_b), .in_data(in_data), .in_valid(in_valid), .in_halted(in_halted),
        .lock(lock), .flush(flush), .out_data(b_data), .out_valid(b_valid), .out_halted(b_halted),
        .stall_cnt(b_stall), .flush_cnt(b_flush));

    pipe_stage_buffer #(.DATA_W(64), .DEPTH(2), .BUBBLE_DATA(BUB_C), .CNT_W(4)) u_c (
        .clk(clk), .rst_b(rst_b), .in_data(in_data), .in_valid(in_valid), .in_halted(in_halted),
        .lock(lock), .flush(flush), .out_data(c_data), .out_valid(c_valid), .out_halted(c_halted),
        .stall_cnt(c_stall), .flush_cnt(c_flush));

    // Reference model: each instance is a line of dep slots; an advance moves every entry one slot on.
    int          dep  [3] = '{1, 3, 2};
    int          cmax [3] = '{65535, 65535, 15};
    logic [63:0] bub  [3] = '{64'h0, 64'h0, BUB_C};
    logic [63:0] md [3][4];
    logic        mv [3][4];
    logic        mh [3][4];
    int          ms [3];
    int          mf [3];

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (rst_b) begin
                for (int k = 0; k < 4; k++) begin md[i][k] = 0; mv[i][k] = 0; mh[i][k] = 0; end
                ms[i] = 0; mf[i] = 0;
            end else if (flush) begin
                for (int k = 0; k < 4; k++) begin md[i][k] = bub[i]; mv[i][k] = 0; mh[i][k] = 0; end
                if (mf[i] < cmax[i]) mf[i]++;
            end else if (lock) begin
                if (ms[i] < cmax[i]) ms[i]++;
            end else begin
                for (int k = 3; k > 0; k--) begin
                    md[i][k] = md[i][k-1]; mv[i][k] = mv[i][k-1]; mh[i][k] = mh[i][k-1];
                end
                md[i][0] = in_data; mv[i][0] = in_valid; mh[i][0] = in_halted;
            end
        end
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_model(string tag);
        logic [63:0] od [3] = '{a_data, b_data, c_data};
        logic        ov [3] = '{a_valid, b_valid, c_valid};
        logic        oh [3] = '{a_halted, b_halted, c_halted};
        int          os [3] = '{int'(a_stall), int'(b_stall), int'(c_stall)};
        int          of [3] = '{int'(a_flush), int'(b_flush), int'(c_flush)};
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_inst%0d_data", tag, i),   od[i], md[i][dep[i]-1]);
            chk($sformatf("%s_inst%0d_valid", tag, i),  64'(ov[i]), 64'(mv[i][dep[i]-1]));
            chk($sformatf("%s_inst%0d_halted", tag, i), 64'(oh[i]), 64'(mh[i][dep[i]-1]));
            chk($sformatf("%s_inst%0d_stall", tag, i),  64'(os[i]), 64'(ms[i]));
            chk($sformatf("%s_inst%0d_flush", tag, i),  64'(of[i]), 64'(mf[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(logic r, logic f, logic l, logic [63:0] d, logic v, logic h);
        rst_b = r; flush = f; lock = l; in_data = d; in_valid = v; in_halted = h;
    endtask

    typedef struct {
        logic        rst, fl, lk;
        logic [63:0] d;
        logic        v, h;
        logic [63:0] e_data;
        logic        e_valid, e_halted;
        int          e_stall, e_flush;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // Expectations for the DEPTH=1 instance, sampled after each edge.
        tbl[0]  = '{1, 1, 1, 64'h0,               0, 0, 64'h0,               0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 64'h2008000500400004, 1, 0, 64'h2008000500400004, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 64'hA,               1, 1, 64'hA,               1, 1, 0, 0};
        tbl[3]  = '{0, 0, 1, 64'hB,               1, 0, 64'hA,               1, 1, 1, 0};
        tbl[4]  = '{0, 0, 1, 64'hB,               1, 0, 64'hA,               1, 1, 2, 0};
        tbl[5]  = '{0, 0, 1, 64'hB,               1, 0, 64'hA,               1, 1, 3, 0};
        tbl[6]  = '{0, 0, 1, 64'hB,               1, 0, 64'hA,               1, 1, 4, 0};
        tbl[7]  = '{0, 0, 0, 64'hB,               1, 0, 64'hB,               1, 0, 4, 0};
        tbl[8]  = '{0, 0, 0, 64'hA,               1, 1, 64'hA,               1, 1, 4, 0};
        tbl[9]  = '{0, 1, 1, 64'hB,               1, 1, 64'h0,               0, 0, 4, 1};
        tbl[10] = '{0, 0, 0, 64'hC,               0, 1, 64'hC,               0, 1, 4, 1};
        tbl[11] = '{1, 0, 1, 64'hD,               1, 1, 64'h0,               0, 0, 0, 0};

        drive(1, 0, 0, 0, 0, 0);
        step();
        for (int n = 0; n < 12; n++) begin
            drive(tbl[n].rst, tbl[n].fl, tbl[n].lk, tbl[n].d, tbl[n].v, tbl[n].h);
            step();
            chk($sformatf("tbl%0d_data", n),   a_data,          tbl[n].e_data);
            chk($sformatf("tbl%0d_valid", n),  64'(a_valid),    64'(tbl[n].e_valid));
            chk($sformatf("tbl%0d_halted", n), 64'(a_halted),   64'(tbl[n].e_halted));
            chk($sformatf("tbl%0d_stall", n),  64'(a_stall),    64'(tbl[n].e_stall));
            chk($sformatf("tbl%0d_flush", n),  64'(a_flush),    64'(tbl[n].e_flush));
            check_model($sformatf("tbl%0d", n));
        end

        // DEPTH=3 latency and DEPTH=2 halt propagation.
        drive(1, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 64'h2008000500400004, 1, 1); step();
        drive(0, 0, 0, 64'h0, 0, 0);
        chk("lat_e1_b_valid", 64'(b_valid), 64'd0);
        chk("lat_e1_c_halted", 64'(c_halted), 64'd0);
        step();
        chk("lat_e2_b_valid", 64'(b_valid), 64'd0);
        chk("lat_e2_c_halted", 64'(c_halted), 64'd1);
        step();
        chk("lat_e3_b_valid", 64'(b_valid), 64'd1);
        chk("lat_e3_b_data", b_data, 64'h2008000500400004);
        chk("lat_e3_c_halted", 64'(c_halted), 64'd0);
        check_model("lat");

        drive(0, 0, 0, 64'h5, 1, 1); step();
        drive(0, 1, 0, 64'h0, 0, 0); step();
        drive(0, 0, 0, 64'h0, 0, 0);
        chk("haltflush_e2_c_halted", 64'(c_halted), 64'd0);
        chk("haltflush_e2_c_data", c_data, BUB_C);
        step();
        chk("haltflush_e3_c_halted", 64'(c_halted), 64'd0);
        check_model("haltflush");

        // Counter saturation on the 4-bit instance.
        drive(1, 0, 0, 0, 0, 0); step();
        drive(0, 0, 1, 64'h7, 1, 0);
        for (int n = 1; n <= 20; n++) begin
            step();
            chk($sformatf("sat%0d_c_stall", n), 64'(c_stall), 64'(n < 15 ? n : 15));
        end
        chk("sat_a_stall", 64'(a_stall), 64'd20);
        check_model("sat");

        // Randomised traffic against the model.
        drive(1, 0, 0, 0, 0, 0); step();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                  {$urandom, $urandom}, 1'($urandom), 1'($urandom));
            step();
            check_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
